// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
//   Shared constants and types for the direct-mapped data-cache controller.
//   - CPU word address split: tag [23:8], index [7:2], word select [1:0].
//   - Line RAM entry (82 bits): bit 0 valid, bit 1 dirty, [17:2] tag,
//     [81:18] four 16-bit data words (word w at DATA_LSB + 16*w).
//   - FSM state encoding for the controller.
//   - Helpers: word extraction from a 64-bit line, saturating 16-bit increment.
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_W       = 24;
    localparam int TAG_W        = 16;
    localparam int IDX_W        = 6;
    localparam int WSEL_W       = 2;
    localparam int DATA_W       = 16;
    localparam int LDATA_W      = 64;
    localparam int LINE_W       = 82;
    localparam int MADDR_W      = TAG_W + IDX_W;
    localparam int STAT_W       = 16;

    localparam int IDX_LSB      = WSEL_W;
    localparam int TAG_ADDR_LSB = WSEL_W + IDX_W;

    localparam int VALID_BIT    = 0;
    localparam int DIRTY_BIT    = 1;
    localparam int TAG_LSB      = 2;
    localparam int DATA_LSB     = 18;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_REFILL    = 2'd3
    } state_e;

    // Word sel of a 64-bit line; {sel, 4'b0} is the bit offset sel*16.
    function automatic logic [DATA_W-1:0] line_word(
        input logic [LDATA_W-1:0] line,
        input logic [WSEL_W-1:0]  sel
    );
        return line[{sel, 4'b0000} +: DATA_W];
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// -----------------------------------------------------------------------------
// dcache_line_merge
//   Combinational insertion of one 16-bit word into a 64-bit cache line.
//   Ports:
//     i_line      64-bit source line
//     i_word_sel  2-bit word index to replace
//     i_word      16-bit replacement word
//     o_line      64-bit line with the selected word replaced
// -----------------------------------------------------------------------------
module dcache_line_merge
    import dcache_pkg::*;
(
    input  logic [LDATA_W-1:0] i_line,
    input  logic [WSEL_W-1:0]  i_word_sel,
    input  logic [DATA_W-1:0]  i_word,
    output logic [LDATA_W-1:0] o_line
);

    always_comb begin
        o_line = i_line;
        o_line[{i_word_sel, 4'b0000} +: DATA_W] = i_word;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped data-cache controller; sole initiator of the 64 x 82-bit
//   line RAM. Serves 16-bit CPU loads/stores, compares tags, writes back dirty
//   victims and refills lines over a 64-bit line-wide memory port.
//
//   Ports:
//     i_clk, i_rst_n            clock, asynchronous active-low reset
//     i_req/i_we/i_addr/i_data  CPU request (held by the CPU until o_ack)
//     o_data/o_ack              load data and one-cycle completion pulse
//     o_ram_addr/o_ram_data/o_ram_we/i_ram_data
//                               line RAM port (1-cycle synchronous read)
//     o_mem_req/o_mem_we/o_mem_addr/o_mem_data/i_mem_data/i_mem_ack
//                               line transfer port (writeback / refill)
//
//   Optional build macro DCACHE_STATS_EN adds o_hit_cnt / o_miss_cnt, two
//   saturating 16-bit counters of LOOKUP hits and misses.
// -----------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [DATA_W-1:0]  i_data,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_ack,
    output logic [IDX_W-1:0]   o_ram_addr,
    output logic [LINE_W-1:0]  o_ram_data,
    output logic               o_ram_we,
    input  logic [LINE_W-1:0]  i_ram_data,
    output logic               o_mem_req,
    output logic               o_mem_we,
    output logic [MADDR_W-1:0] o_mem_addr,
    output logic [LDATA_W-1:0] o_mem_data,
    input  logic [LDATA_W-1:0] i_mem_data,
    input  logic               i_mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]  o_hit_cnt,
    output logic [STAT_W-1:0]  o_miss_cnt
`endif
);

    state_e              state_q, state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [TAG_W-1:0]    vic_tag_q;
    logic [LDATA_W-1:0]  vic_data_q;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WSEL_W-1:0]   req_word;

    logic                ram_valid;
    logic                ram_dirty;
    logic [TAG_W-1:0]    ram_tag;
    logic [LDATA_W-1:0]  ram_line;
    logic                hit;

    logic [LDATA_W-1:0]  merge_base;
    logic [LDATA_W-1:0]  merged_line;

    assign req_tag   = addr_q[TAG_ADDR_LSB +: TAG_W];
    assign req_idx   = addr_q[IDX_LSB +: IDX_W];
    assign req_word  = addr_q[WSEL_W-1:0];

    assign ram_valid = i_ram_data[VALID_BIT];
    assign ram_dirty = i_ram_data[DIRTY_BIT];
    assign ram_tag   = i_ram_data[TAG_LSB +: TAG_W];
    assign ram_line  = i_ram_data[DATA_LSB +: LDATA_W];
    assign hit       = ram_valid && (ram_tag == req_tag);

    // A store merges into the RAM line on a hit, into the fetched line on refill.
    assign merge_base = (state_q == ST_REFILL) ? i_mem_data : ram_line;

    dcache_line_merge u_merge (
        .i_line     (merge_base),
        .i_word_sel (req_word),
        .i_word     (wdata_q),
        .o_line     (merged_line)
    );

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- request / victim capture (data only, no reset) ----------------
    always_ff @(posedge i_clk) begin
        if (state_q == ST_IDLE && i_req) begin
            addr_q  <= i_addr;
            we_q    <= i_we;
            wdata_q <= i_data;
        end
        // The RAM read port may change later, so keep the victim for WRITEBACK.
        if (state_q == ST_LOOKUP) begin
            vic_tag_q  <= ram_tag;
            vic_data_q <= ram_line;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit)                         state_d = ST_IDLE;
                else if (ram_valid && ram_dirty) state_d = ST_WRITEBACK;
                else                             state_d = ST_REFILL;
            end
            ST_WRITEBACK: begin
                if (i_mem_ack) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                if (i_mem_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        o_data     = '0;
        o_ack      = 1'b0;
        o_ram_addr = req_idx;
        o_ram_data = '0;
        o_ram_we   = 1'b0;
        o_mem_req  = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                // Present the index straight away so the read lands in LOOKUP.
                o_ram_addr = i_addr[IDX_LSB +: IDX_W];
            end
            ST_LOOKUP: begin
                if (hit) begin
                    o_ack = 1'b1;
                    if (we_q) begin
                        o_ram_we   = 1'b1;
                        o_ram_data = {merged_line, req_tag, 1'b1, 1'b1};
                    end else begin
                        o_data = line_word(ram_line, req_word);
                    end
                end
            end
            ST_WRITEBACK: begin
                o_mem_req  = 1'b1;
                o_mem_we   = 1'b1;
                o_mem_addr = {vic_tag_q, req_idx};
                o_mem_data = vic_data_q;
            end
            ST_REFILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {req_tag, req_idx};
                if (i_mem_ack) begin
                    o_ack      = 1'b1;
                    o_ram_we   = 1'b1;
                    o_ram_data = {(we_q ? merged_line : i_mem_data), req_tag, we_q, 1'b1};
                    if (!we_q) o_data = line_word(i_mem_data, req_word);
                end
            end
            default: ;
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit) hit_cnt_q  <= sat_inc(hit_cnt_q);
            else     miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [23:0] i_addr = '0;
    logic [15:0] i_data = '0;
    logic [15:0] o_data;
    logic        o_ack;
    logic [5:0]  o_ram_addr;
    logic [81:0] o_ram_data;
    logic        o_ram_we;
    logic [81:0] i_ram_data = '0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [21:0] o_mem_addr;
    logic [63:0] o_mem_data;
    logic [63:0] i_mem_data = '0;
    logic        i_mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [15:0] o_hit_cnt;
    logic [15:0] o_miss_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    dcache_ctrl dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_data     (o_data),
        .o_ack      (o_ack),
        .o_ram_addr (o_ram_addr),
        .o_ram_data (o_ram_data),
        .o_ram_we   (o_ram_we),
        .i_ram_data (i_ram_data),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .i_mem_data (i_mem_data),
        .i_mem_ack  (i_mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .o_hit_cnt  (o_hit_cnt),
        .o_miss_cnt (o_miss_cnt)
`endif
    );

    // Line RAM: synchronous write, 1-cycle synchronous read, cleared by its own reset.
    logic [81:0] ram [64];
    logic        ram_clr = 1'b1;

    always @(posedge i_clk) begin
        if (ram_clr) begin
            for (int k = 0; k < 64; k++) ram[k] <= '0;
        end else if (o_ram_we) begin
            ram[o_ram_addr] <= o_ram_data;
        end
        i_ram_data <= ram[o_ram_addr];
    end

    // Backing store seen by the memory side, and the CPU-visible flat word memory.
    logic [63:0] bmem [logic [21:0]];
    logic [15:0] fmem [logic [23:0]];

    // Cache occupancy model: which line each index holds and whether it is dirty.
    bit          c_valid [64];
    bit          c_dirty [64];
    logic [15:0] c_tag   [64];

    // Observations of the last transaction.
    int          obs_lat, obs_nwb, obs_nrf, obs_reqcyc;
    bit          obs_tmo;
    logic [15:0] obs_rdata;
    logic [21:0] obs_wbaddr, obs_rfaddr;
    logic [63:0] obs_wbdata;

    function automatic logic [63:0] init_line(input logic [21:0] la);
        if (la == 22'h0048D1) return 64'h4444_3333_2222_1111;
        if (la == 22'h2AF351) return 64'h8888_7777_6666_5555;
        return {la[15:0] ^ 16'h1357, la[21:6] ^ 16'h2468, la[15:0] ^ 16'h9ABC, ~la[15:0]};
    endfunction

    function automatic logic [63:0] mem_line(input logic [21:0] la);
        if (bmem.exists(la)) return bmem[la];
        return init_line(la);
    endfunction

    function automatic logic [15:0] ref_word(input logic [23:0] a);
        logic [63:0] l;
        if (fmem.exists(a)) return fmem[a];
        l = init_line(a[23:2]);
        return l[a[1:0]*16 +: 16];
    endfunction

    function automatic logic [63:0] ref_line(input logic [21:0] la);
        return {ref_word({la, 2'd3}), ref_word({la, 2'd2}), ref_word({la, 2'd1}), ref_word({la, 2'd0})};
    endfunction

    task automatic check(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one CPU request and act as the memory side until o_ack or the cycle budget.
    task automatic run_op(input logic w, input logic [23:0] a, input logic [15:0] d,
                          input int dwb, input int drf);
        int waited;
        waited     = 0;
        obs_lat    = 0;
        obs_nwb    = 0;
        obs_nrf    = 0;
        obs_reqcyc = 0;
        obs_tmo    = 1'b1;
        obs_rdata  = '0;
        obs_wbaddr = '0;
        obs_wbdata = '0;
        obs_rfaddr = '0;
        @(negedge i_clk);
        i_req  = 1'b1;
        i_we   = w;
        i_addr = a;
        i_data = d;
        for (int c = 1; c <= 100; c++) begin
            @(posedge i_clk);
            #1;
            i_mem_ack = 1'b0;
            #1;
            if (o_mem_req) begin
                obs_reqcyc++;
                if (waited >= (o_mem_we ? dwb : drf)) begin
                    if (o_mem_we) begin
                        obs_nwb++;
                        obs_wbaddr = o_mem_addr;
                        obs_wbdata = o_mem_data;
                        bmem[o_mem_addr] = o_mem_data;
                        i_mem_data = {$urandom, $urandom};
                    end else begin
                        obs_nrf++;
                        obs_rfaddr = o_mem_addr;
                        i_mem_data = mem_line(o_mem_addr);
                    end
                    i_mem_ack = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                    i_mem_data = {$urandom, $urandom};
                end
                #1;
            end
            if (o_ack) begin
                obs_lat   = c;
                obs_rdata = o_data;
                obs_tmo   = 1'b0;
                i_req     = 1'b0;
                break;
            end
        end
        i_req = 1'b0;
        @(posedge i_clk);
        #1;
        i_mem_ack = 1'b0;
    endtask

    // Predict from the cache rules, run the transaction, compare.
    task automatic op(input string tag, input logic w, input logic [23:0] a,
                      input logic [15:0] d, input int dwb, input int drf);
        logic [5:0]  idx;
        logic [15:0] tg;
        bit          hit, wb;
        logic [21:0] ewb_a;
        logic [63:0] ewb_d;
        logic [15:0] erd;
        int          elat, ereq;
        idx   = a[7:2];
        tg    = a[23:8];
        hit   = c_valid[idx] && (c_tag[idx] == tg);
        wb    = !hit && c_valid[idx] && c_dirty[idx];
        ewb_a = {c_tag[idx], idx};
        ewb_d = ref_line(ewb_a);
        erd   = ref_word(a);
        elat  = hit ? 1 : (wb ? 3 + dwb + drf : 2 + drf);
        ereq  = hit ? 0 : (wb ? dwb + drf + 2 : drf + 1);
        if (!hit) begin
            c_valid[idx] = 1'b1;
            c_tag[idx]   = tg;
            c_dirty[idx] = w;
        end else if (w) begin
            c_dirty[idx] = 1'b1;
        end
        if (w) fmem[a] = d;
        run_op(w, a, d, dwb, drf);
        check({tag, " timeout"}, obs_tmo, 0);
        check({tag, " latency"}, obs_lat, elat);
        if (!w) check({tag, " load data"}, obs_rdata, erd);
        check({tag, " mem req cycles"}, obs_reqcyc, ereq);
        check({tag, " writebacks"}, obs_nwb, wb);
        if (wb) begin
            check({tag, " wb addr"}, obs_wbaddr, ewb_a);
            check({tag, " wb data"}, obs_wbdata, ewb_d);
        end
        check({tag, " refills"}, obs_nrf, hit ? 0 : 1);
        if (!hit) check({tag, " refill addr"}, obs_rfaddr, {tg, idx});
    endtask

    initial begin
        logic [15:0] tags [4];
        logic [81:0] snap;
        logic [5:0]  ridx;
        logic [23:0] raddr;
        bit          found;
        tags = '{16'h0123, 16'hABCD, 16'h5555, 16'hF00F};
        for (int k = 0; k < 64; k++) begin
            c_valid[k] = 1'b0;
            c_dirty[k] = 1'b0;
            c_tag[k]   = '0;
        end

        // Reset state.
        #1;
        i_rst_n = 1'b0;
        i_addr  = 24'h000ABC;
        #2;
        check("rst o_ack", o_ack, 0);
        check("rst o_ram_we", o_ram_we, 0);
        check("rst o_mem_req", o_mem_req, 0);
        check("rst o_mem_we", o_mem_we, 0);
        check("rst o_data", o_data, 0);
        check("rst o_mem_addr", o_mem_addr, 0);
        check("rst o_mem_data", o_mem_data, 0);
        check("idle ram addr", o_ram_addr, 6'h2F);
`ifdef DCACHE_STATS_EN
        check("rst hit cnt", o_hit_cnt, 0);
        check("rst miss cnt", o_miss_cnt, 0);
`endif
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        ram_clr = 1'b0;

        // Directed sequence.
        op("load miss", 1'b0, 24'h012345, 16'h0, 0, 0);
        check("load miss data", obs_rdata, 16'h2222);
        check("load miss refill addr", obs_rfaddr, 22'h0048D1);
        check("load miss ram line", ram[6'h11], {64'h4444_3333_2222_1111, 16'h0123, 1'b0, 1'b1});

        op("reload hit", 1'b0, 24'h012345, 16'h0, 0, 0);
        check("reload hit data", obs_rdata, 16'h2222);

        op("store hit", 1'b1, 24'h012344, 16'hBEEF, 0, 0);
        check("store hit ram line", ram[6'h11], {64'h4444_3333_2222_BEEF, 16'h0123, 1'b1, 1'b1});

        op("dirty miss", 1'b0, 24'hABCD44, 16'h0, 2, 1);
        check("dirty miss wb data", obs_wbdata, 64'h4444_3333_2222_BEEF);
        check("dirty miss wb addr", obs_wbaddr, 22'h0048D1);
        check("dirty miss refill addr", obs_rfaddr, 22'h2AF351);
        check("dirty miss data", obs_rdata, 16'h5555);
`ifdef DCACHE_STATS_EN
        check("seq hit cnt", o_hit_cnt, 2);
        check("seq miss cnt", o_miss_cnt, 2);
`endif

        // Reset during REFILL: drop the request, no RAM write.
        @(negedge i_clk);
        i_req  = 1'b1;
        i_we   = 1'b0;
        i_addr = 24'h555508;
        found  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_clk);
            #2;
            if (o_mem_req && !o_mem_we) begin
                found = 1'b1;
                break;
            end
        end
        check("rst-test reached refill", found, 1);
        snap = ram[6'h02];
        i_rst_n = 1'b0;
        #1;
        check("mid-rst o_mem_req", o_mem_req, 0);
        check("mid-rst o_ack", o_ack, 0);
        check("mid-rst o_ram_we", o_ram_we, 0);
        check("mid-rst o_mem_addr", o_mem_addr, 0);
        i_req      = 1'b0;
        i_mem_data = 64'hDEAD_BEEF_CAFE_F00D;
        i_mem_ack  = 1'b1;
        @(posedge i_clk);
        #1;
        check("mid-rst edge o_ack", o_ack, 0);
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("mid-rst ram untouched", ram[6'h02], snap);
        check("mid-rst line kept", ram[6'h11], {64'h8888_7777_6666_5555, 16'hABCD, 1'b0, 1'b1});
`ifdef DCACHE_STATS_EN
        check("post-rst hit cnt", o_hit_cnt, 0);
        check("post-rst miss cnt", o_miss_cnt, 0);
`endif
        op("reissue", 1'b0, 24'h555508, 16'h0, 0, 1);

        // Randomized traffic over a few conflicting tags and indices.
        for (int n = 0; n < 250; n++) begin
            ridx  = ($urandom_range(0, 8) == 8) ? 6'h11 : 6'($urandom_range(0, 7));
            raddr = {tags[$urandom_range(0, 3)], ridx, 2'($urandom_range(0, 3))};
            op("rand", 1'($urandom_range(0, 1)), raddr, 16'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3));
        end

`ifdef DCACHE_STATS_EN
        // Continuous hits to drive the hit counter into saturation.
        op("sat warm", 1'b0, 24'h555508, 16'h0, 0, 0);
        @(negedge i_clk);
        i_req  = 1'b1;
        i_we   = 1'b0;
        i_addr = 24'h555508;
        repeat (2 * 65540) @(posedge i_clk);
        @(negedge i_clk);
        i_req = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("hit cnt saturated", o_hit_cnt, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped data-cache controller that drives the 64-entry × 82-bit dcache line RAM as its only initiator. It serves 16-bit CPU loads and stores, performs tag compare, and handles dirty-line writeback and line refill over a 64-bit line-wide memory port. It sits between the CPU load/store unit and the memory bus arbiter, beside the line RAM instance.

## Interface
Parameters:
- none; all widths are fixed constants in `dcache_pkg`.

Ports:
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset; asynchronous, active-low
- `i_req`  in  1  CPU request; sampled only in IDLE
- `i_we`  in  1  1 = store, 0 = load
- `i_addr`  in  24  word address: tag [23:8], index [7:2], word [1:0]
- `i_data`  in  16  store data
- `o_data`  out  16  load data; valid when `o_ack` = 1
- `o_ack`  out  1  one-cycle completion pulse
- `o_ram_addr`  out  6  line RAM index
- `o_ram_data`  out  82  line RAM write data
- `o_ram_we`  out  1  line RAM write enable
- `i_ram_data`  in  82  line RAM read data; 1-cycle synchronous read
- `o_mem_req`  out  1  memory line transfer request
- `o_mem_we`  out  1  1 = writeback, 0 = refill
- `o_mem_addr`  out  22  line address {tag, index}
- `o_mem_data`  out  64  writeback line
- `i_mem_data`  in  64  refill line; valid with `i_mem_ack`
- `i_mem_ack`  in  1  one-cycle transfer-done pulse

## Operation
- Line format: bit 0 = valid, bit 1 = dirty, [17:2] = tag, [81:18] = data. Word w occupies [18+16w +: 16].
- The controller does not clear the RAM. Valid/dirty clearing is done by the RAM's own reset.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL.
- IDLE:
  - `o_ram_addr` = `i_addr[7:2]` (combinational).
  - When `i_req` = 1, latch addr, we and data, then go to LOOKUP.
- LOOKUP: hit = valid && tag match.
  - Load hit: `o_ack` = 1 and `o_data` = selected word; go to IDLE.
  - Store hit: write the merged line with dirty = 1, `o_ack` = 1; go to IDLE.
  - Miss with a valid dirty victim: go to WRITEBACK, capturing the victim line.
  - Otherwise: go to REFILL.
- WRITEBACK:
  - `o_mem_req` = 1, `o_mem_we` = 1, `o_mem_addr` = {victim tag, index}, `o_mem_data` = victim data.
  - On `i_mem_ack`, go to REFILL.
- REFILL:
  - `o_mem_req` = 1, `o_mem_we` = 0, `o_mem_addr` = {req tag, index}.
  - On `i_mem_ack`, write the RAM line {i_mem_data merged with store word if store, tag, dirty = we, valid = 1}.
  - In the same cycle, `o_ack` = 1; `o_data` = word from `i_mem_data` on a load.
  - Go to IDLE.
- `o_ram_addr` in states other than IDLE = latched index.
- `o_mem_req` is state-decoded. It stays high through the ack cycle and is low the cycle after.
- `i_req` outside IDLE is ignored. The CPU holds its request until `o_ack`.
- `i_mem_ack` outside WRITEBACK/REFILL is ignored.

## Timing
- Reset values: state IDLE; `o_ack`, `o_ram_we`, `o_mem_req`, `o_mem_we` = 0; `o_data`, `o_mem_addr`, `o_mem_data` = 0.
- Hit latency: request accepted at edge N, `o_ack` high in cycle N+1. Throughput is one hit per 2 cycles.
- Clean miss: `o_ack` is high in the cycle `i_mem_ack` arrives, at the earliest 2 cycles after the request.
- Dirty miss: adds one full memory handshake before the refill.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs at reset values; the pending request is dropped.
  - RAM writes already committed remain.
  - The memory side must abort its transfer on the same reset.
- A RAM write in the ack cycle is visible to a lookup issued in the following IDLE cycle.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `o_hit_cnt` [15:0] and `o_miss_cnt` [15:0].
  - Each counter increments once per LOOKUP hit or miss and saturates at 16'hFFFF.
  - Both are cleared by `i_rst_n`.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

## Structure
- `dcache_pkg`:
  - Constants for address split widths, line field offsets (VALID_BIT, DIRTY_BIT, TAG_LSB, DATA_LSB), and line width 82.
  - The FSM state typedef.
- Sub-module `dcache_line_merge`: combinational insertion of a 16-bit word into a 64-bit line by word index. Used in LOOKUP store hit and REFILL store.

## Test plan
- Load miss on a clean invalid line, addr 24'h012345 → mem refill read at line addr 22'h0048D1; returned line 64'h4444_3333_2222_1111 → `o_ack` with `o_data` 16'h2222; RAM line valid = 1, dirty = 0, tag 16'h0123.
- Reload of 24'h012345 → hit, `o_ack` 1 cycle after accept, `o_data` 16'h2222, no `o_mem_req`.
- Store 16'hBEEF to 24'h012344 → hit; RAM word 0 = 16'hBEEF, dirty = 1; no memory traffic.
- Load 24'hABCD44 (same index, other tag) → writeback of 64'h4444_3333_2222_BEEF to 22'h0048D1, then refill from 22'h2AF351; `o_ack` only after the second `i_mem_ack`.
- `i_rst_n` pulsed low during REFILL → `o_mem_req` = 0 immediately, no `o_ack`, no RAM write; the reissued request completes normally.
- With `DCACHE_STATS_EN`: the above sequence gives `o_hit_cnt` = 2, `o_miss_cnt` = 2; saturation check forces 65535 hits and verifies the counter holds 16'hFFFF.
